// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for pipe_stage_buf: occupancy state encoding and a
// helper that maps the registered state onto the occupancy count.
// Imported by pipe_stage_buf; holds no logic of its own.
package pipe_stage_buf_pkg;

    // EMPTY: nothing held, ONE: main register valid, FULL: main + skid valid
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_t;

    // Occupancy comes straight from the state register, so it never glitches
    // with same-cycle handshakes.
    function automatic logic [1:0] occ_of(input ps_state_t s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Purpose : valid/ready pipeline stage buffer carrying payload + kill tag, with stall and flush.
// Latency : 1 cycle (entry enqueued in cycle N is presented in cycle N+1, no bypass).
// Backpr. : SKID=1 -> 2-entry skid, in_ready from registered state only; SKID=0 -> in_ready follows out_ready.
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   stall, flush                  hold everything / discard all entries (flush wins)
//   in_valid, in_ready            upstream handshake; in_data, in_kill are the entry
//   out_valid, out_ready          downstream handshake; out_data, out_kill are the head entry
//   occupancy                     entries held (0..2, max 1 when SKID=0)
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned        DATA_W   = 96,
    parameter bit                 SKID     = 1'b1,
    parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_kill,
    output logic [1:0]        occupancy
);

    ps_state_t         state_q, state_d;
    logic [DATA_W-1:0] main_dat_q, main_dat_d;
    logic              main_kill_q, main_kill_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
    logic              skid_kill_q, skid_kill_d;
    logic              in_fire, out_fire;

    generate
        if (SKID) begin : g_skid
            // Only the registered state decides acceptance: no comb path from out_ready.
            assign in_ready = (state_q != PS_FULL) && !stall && !rst;
        end else begin : g_noskid
            // Single register: may accept while the head leaves in the same cycle.
            assign in_ready = ((state_q == PS_EMPTY) || out_ready) && !stall && !rst;
        end
    endgenerate

    assign out_valid = (state_q != PS_EMPTY) && !stall && !rst;
    assign out_data  = main_dat_q;
    assign out_kill  = main_kill_q;
    assign occupancy = occ_of(state_q);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_dat_d  = main_dat_q;
        main_kill_d = main_kill_q;
        skid_dat_d  = skid_dat_q;
        skid_kill_d = skid_kill_q;
        if (flush) begin
            // Payload registers keep their last value; only validity and kill tags clear.
            // A same-cycle enqueue is dropped; a same-cycle dequeue already left.
            state_d     = PS_EMPTY;
            main_kill_d = 1'b0;
            skid_kill_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_d     = PS_ONE;
                        main_dat_d  = in_data;
                        main_kill_d = in_kill;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_dat_d  = in_data;
                        main_kill_d = in_kill;
                    end else if (in_fire) begin
                        // Only reachable with SKID=1: SKID=0 accepts in ONE only when the head leaves.
                        if (SKID) begin
                            state_d     = PS_FULL;
                            skid_dat_d  = in_data;
                            skid_kill_d = in_kill;
                        end
                    end else if (out_fire) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // Skid entry is promoted behind the departing head, keeping FIFO order.
                    if (out_fire) begin
                        state_d     = PS_ONE;
                        main_dat_d  = skid_dat_q;
                        main_kill_d = skid_kill_q;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PS_EMPTY;
            main_dat_q  <= RST_DATA;
            main_kill_q <= 1'b0;
            skid_dat_q  <= RST_DATA;
            skid_kill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_dat_q  <= main_dat_d;
            main_kill_q <= main_kill_d;
            skid_dat_q  <= skid_dat_d;
            skid_kill_q <= skid_kill_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 instance (96-bit) and a SKID=0
// instance (8-bit) with non-zero reset payloads, driven through reset,
// streaming, backpressure, stall, flush and single-register replacement.
module tb_pipe_stage_buf;

    localparam logic [95:0] RST1 = 96'hDEAD;
    localparam logic [7:0]  RST0 = 8'h3C;

    logic clk = 1'b0;
    logic rst;

    // SKID=1 instance signals
    logic        a_stall, a_flush, a_in_valid, a_in_ready, a_in_kill;
    logic        a_out_valid, a_out_ready, a_out_kill;
    logic [95:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    // SKID=0 instance signals
    logic        b_stall, b_flush, b_in_valid, b_in_ready, b_in_kill;
    logic        b_out_valid, b_out_ready, b_out_kill;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_occ;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(96), .SKID(1'b1), .RST_DATA(RST1)) u_skid (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_kill(a_in_kill),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_kill(a_out_kill),
        .occupancy(a_occ)
    );

    pipe_stage_buf #(.DATA_W(8), .SKID(1'b0), .RST_DATA(RST0)) u_reg (
        .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_kill(b_in_kill),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_kill(b_out_kill),
        .occupancy(b_occ)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge; inputs are changed there
    // and outputs are sampled 1 unit later, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic a_drive(input logic v, input logic [95:0] d, input logic k, input logic ordy);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_kill   = k;
        a_out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1;
        a_stall = 0; a_flush = 0; a_drive(0, '0, 0, 0);
        b_stall = 0; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_kill = 0; b_out_ready = 0;
        #1;
        // ---- reset state ----
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_occ", a_occ, 0);
        chk("rst_a_out_data", a_out_data, RST1);
        chk("rst_a_out_kill", a_out_kill, 0);
        chk("rst_b_out_data", b_out_data, RST0);
        tick(); rst = 1'b0; #1;
        chk("rel_a_in_ready", a_in_ready, 1);
        chk("rel_a_out_data", a_out_data, RST1);

        // ---- streaming 1,2,3 ----
        a_drive(1, 96'h1, 0, 1); #1;
        chk("str_first_out_valid", a_out_valid, 0);
        tick(); a_drive(1, 96'h2, 0, 1); #1;
        chk("str_out1", a_out_data, 96'h1);
        chk("str_valid1", a_out_valid, 1);
        chk("str_occ1", a_occ, 1);
        chk("str_rdy1", a_in_ready, 1);
        tick(); a_drive(1, 96'h3, 0, 1); #1;
        chk("str_out2", a_out_data, 96'h2);
        chk("str_occ2", a_occ, 1);
        tick(); a_drive(0, 96'h0, 0, 1); #1;
        chk("str_out3", a_out_data, 96'h3);
        chk("str_occ3", a_occ, 1);
        tick(); #1;
        chk("str_drain_occ", a_occ, 0);
        chk("str_drain_valid", a_out_valid, 0);
        chk("str_hold_data", a_out_data, 96'h3);

        // ---- backpressure ----
        a_drive(1, 96'hA, 0, 0);
        tick(); a_drive(1, 96'hB, 0, 0); #1;
        chk("bp_occ1", a_occ, 1);
        chk("bp_head_a", a_out_data, 96'hA);
        tick(); a_drive(1, 96'hEE, 0, 0); #1;
        chk("bp_occ2", a_occ, 2);
        chk("bp_not_ready", a_in_ready, 0);
        chk("bp_full_head", a_out_data, 96'hA);
        a_drive(0, 96'h0, 0, 1); #1;
        chk("bp_rdy_indep", a_in_ready, 0);
        chk("bp_deq_a", a_out_data, 96'hA);
        tick(); #1;
        chk("bp_rdy_back", a_in_ready, 1);
        chk("bp_deq_b", a_out_data, 96'hB);
        chk("bp_occ_after", a_occ, 1);
        tick(); #1;
        chk("bp_empty", a_occ, 0);

        // ---- stall while FULL ----
        a_drive(1, 96'hA, 0, 0);
        tick(); a_drive(1, 96'hB, 0, 0);
        tick(); a_drive(1, 96'hC, 0, 1); a_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", a_out_valid, 0);
            chk("stall_rdy", a_in_ready, 0);
            chk("stall_occ", a_occ, 2);
            tick();
        end
        a_stall = 0; a_drive(0, 96'h0, 0, 1); #1;
        chk("stall_rel_valid", a_out_valid, 1);
        chk("stall_rel_a", a_out_data, 96'hA);
        tick(); #1;
        chk("stall_rel_b", a_out_data, 96'hB);
        chk("stall_rel_occ", a_occ, 1);
        tick(); #1;
        chk("stall_rel_empty", a_out_valid, 0);

        // ---- flush while FULL (head A carries kill=1) ----
        a_drive(1, 96'hA, 1, 0);
        tick(); a_drive(1, 96'hB, 0, 0);
        tick(); #1;
        chk("fl_kill_head", a_out_kill, 1);
        a_drive(1, 96'hC, 0, 1); a_flush = 1; #1;
        chk("fl_deliver_valid", a_out_valid, 1);
        chk("fl_deliver_a", a_out_data, 96'hA);
        tick(); a_flush = 0; a_drive(0, 96'h0, 0, 1); #1;
        chk("fl_occ", a_occ, 0);
        chk("fl_valid", a_out_valid, 0);
        chk("fl_kill_clr", a_out_kill, 0);
        chk("fl_payload_kept", a_out_data, 96'hA);
        tick(); #1;
        chk("fl_no_c", a_out_valid, 0);
        a_drive(1, 96'hD, 0, 0);
        tick(); a_drive(0, 96'h0, 0, 0); a_stall = 1; a_flush = 1;
        tick(); a_stall = 0; a_flush = 0; #1;
        chk("flst_occ", a_occ, 0);
        chk("flst_valid", a_out_valid, 0);

        // ---- SKID=0 single register ----
        b_in_valid = 1; b_in_data = 8'h11; b_in_kill = 0; b_out_ready = 0; #1;
        chk("b_rdy_empty", b_in_ready, 1);
        tick(); b_in_data = 8'h22; b_in_kill = 1; #1;
        chk("b_rdy_held", b_in_ready, 0);
        chk("b_out_11", b_out_data, 8'h11);
        chk("b_occ1", b_occ, 1);
        b_out_ready = 1; #1;
        chk("b_rdy_same", b_in_ready, 1);
        tick(); b_in_data = 8'h33; b_in_kill = 0; #1;
        chk("b_out_22", b_out_data, 8'h22);
        chk("b_kill_22", b_out_kill, 1);
        tick(); b_in_valid = 0; #1;
        chk("b_out_33", b_out_data, 8'h33);
        chk("b_kill_33", b_out_kill, 0);
        tick(); #1;
        chk("b_occ0", b_occ, 0);
        chk("b_valid0", b_out_valid, 0);

        // ---- reset mid-stream with SKID=1 FULL ----
        a_drive(1, 96'h5, 0, 0);
        tick(); a_drive(1, 96'h6, 0, 0);
        tick(); #1;
        chk("mrst_pre_occ", a_occ, 2);
        rst = 1; #1;
        chk("mrst_rdy", a_in_ready, 0);
        chk("mrst_valid", a_out_valid, 0);
        chk("mrst_occ", a_occ, 0);
        chk("mrst_data", a_out_data, RST1);
        tick(); rst = 0; a_drive(0, 96'h0, 0, 0); #1;
        chk("mrst_rel_rdy", a_in_ready, 1);
        chk("mrst_rel_data", a_out_data, RST1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
